// File: rtl/core_pkg.sv
// core_pkg: constants and types shared by the RV32I pipeline stages.
package core_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } if_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc: 32'd0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush > hold > load priority; idle cycles insert a bubble.
module if_id_reg
    import core_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    input  logic  hold,
    input  logic  load,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk)
        q <= (rst || flush) ? IFID_BUBBLE : hold ? q : load ? d : IFID_BUBBLE;

endmodule

// File: rtl/if_stage.sv
// if_stage: owns the PC, keeps one fetch outstanding and loads the IF/ID register.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSel,
    input  logic [31:0] ALUOut,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        valid_id
);

    if_state_t   state, state_n;
    logic [31:0] pc, pc_n, buf_inst, buf_n, target, new_inst;
    logic        deliver;
    ifid_t       d, q;

    assign target    = {ALUOut[31:2], 2'b00};
    assign imem_req  = (state == ISSUE) && !PCSel;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            buf_inst <= NOP_INST;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            buf_inst <= buf_n;
        end
    end

    // A redirect always wins; a response that lands during Stall parks in buf_inst.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        buf_n    = buf_inst;
        deliver  = 1'b0;
        new_inst = imem_rdata;
        case (state)
            ISSUE: begin
                pc_n    = PCSel ? target : pc;
                state_n = PCSel ? ISSUE : WAIT;
            end
            WAIT: begin
                if (PCSel) begin
                    pc_n    = target;
                    state_n = imem_ready ? ISSUE : DROP;
                end else if (imem_ready && Stall) begin
                    buf_n   = imem_rdata;
                    state_n = HOLD;
                end else if (imem_ready) begin
                    deliver = 1'b1;
                    pc_n    = pc + 32'd4;
                    state_n = ISSUE;
                end
            end
            DROP: begin
                pc_n    = PCSel ? target : pc;
                state_n = imem_ready ? ISSUE : DROP;
            end
            default: begin
                if (PCSel) begin
                    pc_n    = target;
                    buf_n   = NOP_INST;
                    state_n = ISSUE;
                end else if (!Stall) begin
                    deliver  = 1'b1;
                    new_inst = buf_inst;
                    pc_n     = pc + 32'd4;
                    state_n  = ISSUE;
                end
            end
        endcase
    end

    assign d = '{inst: new_inst, pc: pc, valid: 1'b1};

    if_id_reg u_if_id (
        .clk  (clk),
        .rst  (rst),
        .flush(PCSel),
        .hold (Stall),
        .load (deliver),
        .d    (d),
        .q    (q)
    );

    assign inst_id  = q.inst;
    assign pc_id    = q.pc;
    assign valid_id = q.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized fetch-stage bench with a transaction-level model and IF/ID scoreboard.
module tb_if_stage;

    logic        clk = 1'b0, rst = 1'b1, PCSel = 1'b0, Stall = 1'b0, imem_ready = 1'b0;
    logic [31:0] ALUOut = 32'd0, imem_rdata = 32'd0;
    logic        imem_req, valid_id;
    logic [31:0] imem_addr, inst_id, pc_id;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid;
    } slot_t;

    localparam slot_t BUB = '{inst: 32'h0000_0013, pc: 32'd0, valid: 1'b0};

    int          tests = 0, fails = 0;
    slot_t       exp_q[$], fq[$], cur, mon_e;
    logic [31:0] next_pc, mem_addr;
    bit          outstanding, have, squashed, busy;
    int          cnt, lat = 1;

    if_stage dut (
        .clk       (clk),
        .rst       (rst),
        .PCSel     (PCSel),
        .ALUOut    (ALUOut),
        .Stall     (Stall),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .inst_id   (inst_id),
        .pc_id     (pc_id),
        .valid_id  (valid_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h20) ? 32'hDEAD_BEEF : {a[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // IF/ID monitor: one expected entry per clock, compared once registers have settled.
    always @(posedge clk) begin
        #3;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("valid_id", {31'd0, valid_id}, {31'd0, mon_e.valid});
            check("inst_id", inst_id, mon_e.inst);
            check("pc_id", pc_id, mon_e.pc);
        end
    end

    task automatic do_reset();
        rst = 1'b1; PCSel = 1'b0; Stall = 1'b0; imem_ready = 1'b0;
        busy = 1'b0; cnt = 0;
        @(negedge clk);
        next_pc = 32'd0; outstanding = 1'b0; have = 1'b0; squashed = 1'b0;
        fq.delete(); exp_q.delete();
        cur = BUB;
        exp_q.push_back(BUB);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock of stimulus; the model tracks fetches as transactions, not FSM states.
    task automatic cycle(input logic psel, input logic [31:0] tgt, input logic stl);
        logic  exp_req;
        slot_t nxt;
        PCSel = psel; ALUOut = tgt; Stall = stl;
        if (busy && cnt > 0) cnt--;
        imem_ready = busy && cnt == 0;
        imem_rdata = imem_ready ? mem_word(mem_addr) : $urandom;
        @(negedge clk);
        exp_req = !outstanding && !have && !psel;
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("imem_addr", imem_addr, next_pc);
        if (imem_ready) begin
            if (outstanding && !squashed && !psel) have = 1'b1;
            outstanding = 1'b0;
            squashed = 1'b0;
        end
        if (psel) begin
            squashed = outstanding;
            have = 1'b0;
            fq.delete();
            next_pc = {tgt[31:2], 2'b00};
            nxt = BUB;
        end else if (stl) nxt = cur;
        else if (have && fq.size() > 0) begin
            nxt = fq.pop_front();
            have = 1'b0;
        end else nxt = BUB;
        if (exp_req) begin
            outstanding = 1'b1;
            fq.push_back('{inst: mem_word(next_pc), pc: next_pc, valid: 1'b1});
            next_pc = next_pc + 32'd4;
        end
        cur = nxt;
        exp_q.push_back(nxt);
        if (imem_ready) busy = 1'b0;
        if (imem_req) begin
            busy = 1'b1;
            mem_addr = imem_addr;
            cnt = lat;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        lat = 1;
        repeat (8) cycle(1'b0, 32'd0, 1'b0);

        do_reset();
        lat = 3;
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h103, 1'b0);
        repeat (6) cycle(1'b0, 32'd0, 1'b0);

        do_reset();
        lat = 2;
        cycle(1'b1, 32'h20, 1'b0);
        repeat (5) cycle(1'b0, 32'd0, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b0);
        repeat (4) cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b1, 32'h302, 1'b1);
        repeat (4) cycle(1'b0, 32'd0, 1'b0);

        lat = 1;
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
        repeat (6) cycle(1'b0, 32'd0, 1'b0);

        lat = 5;
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 32'd0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0);
        end
        repeat (6) cycle(1'b0, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
